// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - port indices, flit field helpers and XY route function
package noc_pkg;

    localparam int PORT_N    = 0;
    localparam int PORT_E    = 1;
    localparam int PORT_S    = 2;
    localparam int PORT_W    = 3;
    localparam int PORT_L    = 4;
    localparam int NUM_PORTS = 5;

    function automatic int dst_x_msb(input int datasize);
        return datasize - 1;
    endfunction

    function automatic int dst_y_msb(input int datasize, input int cw);
        return datasize - 1 - cw;
    endfunction

    // Dimension-ordered routing: resolve X first, then Y, then eject locally.
    function automatic logic [2:0] route(input int dst_x, input int dst_y,
                                         input int my_x, input int my_y);
        if (dst_x > my_x)      return 3'(PORT_E);
        else if (dst_x < my_x) return 3'(PORT_W);
        else if (dst_y > my_y) return 3'(PORT_N);
        else if (dst_y < my_y) return 3'(PORT_S);
        else                   return 3'(PORT_L);
    endfunction

endpackage

// File: rtl/noc_switch_alloc_if.sv
// rtl/noc_switch_alloc_if.sv - FIFO-head inputs and output slot bundle of the switch stage
interface noc_switch_alloc_if
    import noc_pkg::*;
#(
    parameter int DATASIZE = 40
);
    logic [NUM_PORTS*DATASIZE-1:0] in_data;
    logic [NUM_PORTS-1:0]          in_valid;
    logic [NUM_PORTS-1:0]          in_ready;
    logic [NUM_PORTS*DATASIZE-1:0] out_data;
    logic [NUM_PORTS-1:0]          out_valid;
    logic [NUM_PORTS-1:0]          out_full;

    modport master (
        output in_data, in_valid, out_full,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_full,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - five-way round-robin arbiter owning its rotating priority pointer
module noc_rr_arbiter
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] gnt
);
    logic [2:0] rr_ptr;
    logic [2:0] start;
    logic [2:0] idx;
    logic [2:0] winner;
    logic       found;

    always_comb begin
        // Pointer codes 5..7 cannot arise but are folded onto 0 for safety.
        start  = (rr_ptr >= 3'(NUM_PORTS)) ? 3'd0 : rr_ptr;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = 3'((32'(start) + k) % NUM_PORTS);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (en && found)
            gnt[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (en && found)
            rr_ptr <= (winner == 3'(NUM_PORTS - 1)) ? 3'd0 : winner + 3'd1;
    end
endmodule

// File: rtl/noc_switch_alloc.sv
// rtl/noc_switch_alloc.sv - XY route, per-output round-robin allocation and registered output slots
module noc_switch_alloc
    import noc_pkg::*;
#(
    parameter int DATASIZE = 40,
    parameter int CW       = 4,
    parameter int MY_X     = 0,
    parameter int MY_Y     = 0
)(
    input  logic               clk,
    input  logic               rst_n,
    noc_switch_alloc_if.slave  bus
);
    localparam int XM = dst_x_msb(DATASIZE);
    localparam int YM = dst_y_msb(DATASIZE, CW);

    logic [DATASIZE-1:0]  flit      [NUM_PORTS];
    logic [2:0]           route_sel [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_all   [NUM_PORTS];
    logic [NUM_PORTS-1:0] ready;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        assign flit[i]      = bus.in_data[i*DATASIZE +: DATASIZE];
        assign route_sel[i] = route(32'(flit[i][XM -: CW]), 32'(flit[i][YM -: CW]), MY_X, MY_Y);
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [NUM_PORTS-1:0] req;
        logic [NUM_PORTS-1:0] gnt;
        logic [DATASIZE-1:0]  win_flit;
        logic [DATASIZE-1:0]  slot_data;
        logic                 slot_valid;
        logic                 en;

        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
            assign req[i] = bus.in_valid[i] && (route_sel[i] == 3'(o));
        end

        // A slot that drains this edge can be refilled on the same edge.
        assign en = !slot_valid || !bus.out_full[o];

        noc_rr_arbiter u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req),
            .en    (en),
            .gnt   (gnt)
        );

        always_comb begin
            win_flit = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                if (gnt[i]) win_flit = win_flit | flit[i];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_valid <= 1'b0;
                slot_data  <= '0;
            end else if (|gnt) begin
                slot_valid <= 1'b1;
                slot_data  <= win_flit;
            end else if (!bus.out_full[o]) begin
                slot_valid <= 1'b0;
            end
        end

        assign gnt_all[o]                              = gnt;
        assign bus.out_valid[o]                        = slot_valid;
        assign bus.out_data[o*DATASIZE +: DATASIZE]    = slot_data;
    end

    always_comb begin
        ready = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            ready = ready | gnt_all[o];
    end

    assign bus.in_ready = ready;
endmodule

// File: tb/tb_noc_switch_alloc.sv
// tb/tb_noc_switch_alloc.sv - directed self-checking bench for noc_switch_alloc at router (1,1)
module tb_noc_switch_alloc;
    localparam int DS = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noc_switch_alloc_if #(.DATASIZE(DS)) bus ();

    noc_switch_alloc #(.DATASIZE(DS), .CW(4), .MY_X(1), .MY_Y(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [DS-1:0] head [5];
    int order [5] = '{0, 2, 3, 4, 0};

    always_comb begin
        bus.in_data = '0;
        for (int i = 0; i < 5; i++)
            bus.in_data[i*DS +: DS] = head[i];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DS-1:0] mk(input logic [3:0] x, input logic [3:0] y, input logic [31:0] p);
        return {x, y, p};
    endfunction

    function automatic logic [DS-1:0] slot(input int o);
        return bus.out_data[o*DS +: DS];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) head[i] = '0;
        bus.in_valid = '0;
        bus.out_full = '0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'h0);
        check("reset_out_data", 64'(bus.out_data != '0), 64'h0);
        check("reset_in_ready", 64'(bus.in_ready), 64'h0);
        rst_n = 1'b1;

        // single local flit from N
        head[0] = mk(4'h1, 4'h1, 32'h1);
        bus.in_valid = 5'b00001;
        #1 check("l_ready", 64'(bus.in_ready), 64'h01);
        tick();
        bus.in_valid = '0;
        #1 check("l_valid", 64'(bus.out_valid), 64'h10);
        check("l_data", 64'(slot(4)), 64'h1100000001);
        check("l_ready_after", 64'(bus.in_ready), 64'h0);
        tick();
        check("l_drained", 64'(bus.out_valid), 64'h0);

        // four inputs contending for E
        head[0] = mk(4'h2, 4'h1, 32'hA0);
        head[2] = mk(4'h2, 4'h1, 32'hA2);
        head[3] = mk(4'h2, 4'h1, 32'hA3);
        head[4] = mk(4'h2, 4'h1, 32'hA4);
        bus.in_valid = 5'b11101;
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("rr_ready_%0d", k), 64'(bus.in_ready), 64'(5'b1 << order[k]));
            tick();
            check($sformatf("rr_valid_%0d", k), 64'(bus.out_valid[1]), 64'h1);
            check($sformatf("rr_data_%0d", k), 64'(slot(1)), 64'(head[order[k]]));
        end

        // backpressure on E holds the slot
        bus.out_full = 5'b00010;
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("bp_ready_%0d", k), 64'(bus.in_ready), 64'h0);
            check($sformatf("bp_valid_%0d", k), 64'(bus.out_valid[1]), 64'h1);
            check($sformatf("bp_data_%0d", k), 64'(slot(1)), 64'(mk(4'h2, 4'h1, 32'hA0)));
            tick();
        end
        bus.out_full = '0;
        #1 check("bp_release_ready", 64'(bus.in_ready), 64'h04);
        tick();
        check("bp_refill_valid", 64'(bus.out_valid[1]), 64'h1);
        check("bp_refill_data", 64'(slot(1)), 64'(mk(4'h2, 4'h1, 32'hA2)));
        bus.in_valid = '0;
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'h0);

        // five inputs to five distinct outputs
        head[0] = mk(4'h1, 4'h2, 32'hB0);
        head[1] = mk(4'h2, 4'h1, 32'hB1);
        head[2] = mk(4'h1, 4'h0, 32'hB2);
        head[3] = mk(4'h0, 4'h1, 32'hB3);
        head[4] = mk(4'h1, 4'h1, 32'hB4);
        bus.in_valid = 5'b11111;
        #1 check("par_ready", 64'(bus.in_ready), 64'h1F);
        tick();
        bus.out_full = 5'b11111;
        check("par_valid", 64'(bus.out_valid), 64'h1F);
        for (int o = 0; o < 5; o++)
            check($sformatf("par_data_%0d", o), 64'(slot(o)), 64'(head[o]));
        #1 check("par_full_ready", 64'(bus.in_ready), 64'h0);

        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1 check("arst_valid", 64'(bus.out_valid), 64'h0);
        check("arst_data", 64'(bus.out_data != '0), 64'h0);
        bus.in_valid = '0;
        bus.out_full = '0;
        @(negedge clk);
        rst_n = 1'b1;
        head[0] = mk(4'h2, 4'h1, 32'hC0);
        head[2] = mk(4'h2, 4'h1, 32'hC2);
        bus.in_valid = 5'b00101;
        #1 check("arst_ptr_ready", 64'(bus.in_ready), 64'h01);
        tick();
        check("arst_ptr_data", 64'(slot(1)), 64'(mk(4'h2, 4'h1, 32'hC0)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
